// File: rtl/pipe_hazard_ctrl.sv
// Pipeline-register and PC control for the 5-stage RV32I core.
// Ports:
//   clk, rst (sync, active-high), ex_stall, flush, redirect_pc, imem_rdata.
//   Outputs: imem_addr, IF/ID, ID/EX, EX/MEM and MEM/WB instruction/PC slots, stage_valid.
//   Optional PIPE_PERF_CNT_EN adds stall_cycles, flush_count and retired.
module pipe_hazard_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned PC_STEP   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] id_ex_instr,
    output logic [31:0] id_ex_pc,
    output logic [31:0] ex_mem_instr,
    output logic [31:0] mem_wb_instr,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
    output logic [31:0] retired,
`endif
    output logic [3:0]  stage_valid
);

    logic [31:0] pc;

    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            if_id_instr  <= NOP_INSTR;
            if_id_pc     <= 32'h0;
            id_ex_instr  <= NOP_INSTR;
            id_ex_pc     <= 32'h0;
            ex_mem_instr <= NOP_INSTR;
            mem_wb_instr <= NOP_INSTR;
            stage_valid  <= 4'b0000;
        end else begin
            // MEM/WB always drains so a stalling load can leave EX/MEM.
            mem_wb_instr   <= ex_mem_instr;
            stage_valid[3] <= stage_valid[2];
            if (ex_stall) begin
                // Stall wins over flush: the branch re-resolves once the stall clears.
                ex_mem_instr   <= NOP_INSTR;
                stage_valid[2] <= 1'b0;
            end else begin
                ex_mem_instr   <= id_ex_instr;
                stage_valid[2] <= stage_valid[1];
                if (flush) begin
                    // The fetched word this cycle is wrong-path and is dropped.
                    pc             <= redirect_pc;
                    if_id_instr    <= NOP_INSTR;
                    if_id_pc       <= 32'h0;
                    id_ex_instr    <= NOP_INSTR;
                    id_ex_pc       <= 32'h0;
                    stage_valid[1] <= 1'b0;
                    stage_valid[0] <= 1'b0;
                end else begin
                    pc             <= pc + 32'(PC_STEP);
                    if_id_instr    <= imem_rdata;
                    if_id_pc       <= pc;
                    id_ex_instr    <= if_id_instr;
                    id_ex_pc       <= if_id_pc;
                    stage_valid[1] <= stage_valid[0];
                    stage_valid[0] <= 1'b1;
                end
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'h0;
            flush_count  <= 32'h0;
            retired      <= 32'h0;
        end else begin
            if (ex_stall)
                stall_cycles <= stall_cycles + 32'h1;
            if (flush && !ex_stall)
                flush_count <= flush_count + 32'h1;
            if (stage_valid[3])
                retired <= retired + 32'h1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl.
// Scoreboard of expected pipeline state, pushed at drive time and popped after each edge.
module tb_pipe_hazard_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ifi;
        logic [31:0] ifp;
        logic [31:0] idi;
        logic [31:0] idp;
        logic [31:0] exi;
        logic [31:0] wbi;
        logic [3:0]  v;
        logic [31:0] sc;
        logic [31:0] fc;
        logic [31:0] rt;
    } st_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] id_ex_instr;
    logic [31:0] id_ex_pc;
    logic [31:0] ex_mem_instr;
    logic [31:0] mem_wb_instr;
    logic [3:0]  stage_valid;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
    logic [31:0] retired;
`endif

    int checks = 0;
    int errors = 0;
    st_t m;
    st_t sb[$];

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hDEAD_0003;
    endfunction

    assign imem_rdata = word(imem_addr);

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk),
        .rst(rst),
        .ex_stall(ex_stall),
        .flush(flush),
        .redirect_pc(redirect_pc),
        .imem_rdata(imem_rdata),
        .imem_addr(imem_addr),
        .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc),
        .id_ex_instr(id_ex_instr),
        .id_ex_pc(id_ex_pc),
        .ex_mem_instr(ex_mem_instr),
        .mem_wb_instr(mem_wb_instr),
`ifdef PIPE_PERF_CNT_EN
        .stall_cycles(stall_cycles),
        .flush_count(flush_count),
        .retired(retired),
`endif
        .stage_valid(stage_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic st_t nxt(input st_t s, input bit r, input bit st,
                                input bit fl, input logic [31:0] rp);
        st_t n;
        n = s;
        if (r) begin
            n.pc = 32'h0;
            n.ifi = NOP; n.ifp = 32'h0;
            n.idi = NOP; n.idp = 32'h0;
            n.exi = NOP; n.wbi = NOP;
            n.v = 4'b0000;
            n.sc = 32'h0; n.fc = 32'h0; n.rt = 32'h0;
            return n;
        end
        if (s.v[3]) n.rt = s.rt + 1;
        n.wbi = s.exi;
        n.v[3] = s.v[2];
        if (st) begin
            n.sc = s.sc + 1;
            n.exi = NOP;
            n.v[2] = 1'b0;
        end else if (fl) begin
            n.fc = s.fc + 1;
            n.exi = s.idi; n.v[2] = s.v[1];
            n.idi = NOP; n.idp = 32'h0; n.v[1] = 1'b0;
            n.ifi = NOP; n.ifp = 32'h0; n.v[0] = 1'b0;
            n.pc = rp;
        end else begin
            n.exi = s.idi; n.v[2] = s.v[1];
            n.idi = s.ifi; n.idp = s.ifp; n.v[1] = s.v[0];
            n.ifi = word(s.pc); n.ifp = s.pc; n.v[0] = 1'b1;
            n.pc = s.pc + 32'd4;
        end
        return n;
    endfunction

    task automatic step(input bit r, input bit st, input bit fl,
                        input logic [31:0] rp);
        st_t e;
        @(negedge clk);
        rst = r; ex_stall = st; flush = fl; redirect_pc = rp;
        sb.push_back(nxt(m, r, st, fl, rp));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'h1, 32'h0);
            return;
        end
        e = sb.pop_front();
        m = e;
        chk("pc", imem_addr, e.pc);
        chk("if_i", if_id_instr, e.ifi);
        chk("if_p", if_id_pc, e.ifp);
        chk("id_i", id_ex_instr, e.idi);
        chk("id_p", id_ex_pc, e.idp);
        chk("ex_i", ex_mem_instr, e.exi);
        chk("wb_i", mem_wb_instr, e.wbi);
        chk("valid", {28'h0, stage_valid}, {28'h0, e.v});
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt", stall_cycles, e.sc);
        chk("flush_cnt", flush_count, e.fc);
        chk("retired", retired, e.rt);
`endif
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        m = nxt(m, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rst_pc", imem_addr, 32'h0);
        chk("rst_v", {28'h0, stage_valid}, 32'h0);

        adv(1);
        chk("rel_ifp", if_id_pc, 32'h0);
        chk("rel_pc1", imem_addr, 32'h4);
        chk("rel_v1", {28'h0, stage_valid}, 32'h1);
        adv(1);
        chk("rel_pc2", imem_addr, 32'h8);
        chk("rel_v2", {28'h0, stage_valid}, 32'h3);
        adv(1);
        chk("rel_v3", {28'h0, stage_valid}, 32'h7);
        adv(1);
        chk("rel_v4", {28'h0, stage_valid}, 32'hF);
        adv(2);
        chk("pre_idp", id_ex_pc, 32'h10);

        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("st1_pc", imem_addr, 32'h18);
        chk("st1_idp", id_ex_pc, 32'h10);
        chk("st1_ex", ex_mem_instr, NOP);
        chk("st1_v", {28'h0, stage_valid}, 32'hB);
        adv(1);
        chk("st1_adv", ex_mem_instr, word(32'h10));
        chk("st1_pc2", imem_addr, 32'h1C);

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            chk("st3_pc", imem_addr, 32'h1C);
            chk("st3_ex", ex_mem_instr, NOP);
        end
        adv(1);
        chk("st3_adv", ex_mem_instr, word(32'h14));
`ifdef PIPE_PERF_CNT_EN
        chk("st3_cnt", stall_cycles, 32'd4);
`endif

        adv(10);
        chk("pre_fl", id_ex_pc, 32'h40);
        step(1'b0, 1'b0, 1'b1, 32'h200);
        chk("fl_pc", imem_addr, 32'h200);
        chk("fl_v", {30'h0, stage_valid[1:0]}, 32'h0);
        chk("fl_ex", ex_mem_instr, word(32'h40));
        adv(1);
        chk("fl_ifp", if_id_pc, 32'h200);
        chk("fl_v0", {31'h0, stage_valid[0]}, 32'h1);

        step(1'b0, 1'b1, 1'b1, 32'h300);
        chk("sf_pc", imem_addr, 32'h204);
        step(1'b0, 1'b0, 1'b1, 32'h300);
        chk("sf_pc2", imem_addr, 32'h300);

        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("wr_pc0", imem_addr, 32'hFFFF_FFFC);
        adv(1);
        chk("wr_pc1", imem_addr, 32'h0);
        chk("wr_ifp", if_id_pc, 32'hFFFF_FFFC);

        adv(3);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h500);
        chk("mr_pc", imem_addr, 32'h0);
        chk("mr_v", {28'h0, stage_valid}, 32'h0);
        chk("mr_id", id_ex_instr, NOP);
`ifdef PIPE_PERF_CNT_EN
        chk("mr_cnt", stall_cycles, 32'h0);
`endif

        for (int i = 0; i < 60; i++) begin
            bit s;
            bit f;
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 4) == 0);
            step(1'b0, s, f, {$urandom_range(0, 255), 2'b00} << 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
